// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller side uses the master modport; the datapath side uses slave.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             iord;
  logic             memwrite;
  logic             irwrite;
  logic             pcwrite;
  logic             branch;
  logic             pcen;
  logic             regwrite;
  logic             regdst;
  logic             memtoreg;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [1:0]       aluop;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcwrite, branch, pcen,
           regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
           illegal, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcwrite, branch, pcen,
           regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
           illegal, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the shared-memory multicycle datapath, with a
// mem_ready handshake that stalls any memory access state.
//
// state  | meaning
// RST    | reset, all outputs low
// FETCH  | read instruction at PC, PC += 4 when memory is ready
// DECODE | read registers, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | load data read
// MEMWB  | load writeback
// MEMWR  | store data write
// EXEC   | R-type ALU operation
// ALUWB  | R-type writeback
// BRANCH | BEQ compare and conditional PC write
// ADDIEX | ADDI ALU operation
// ADDIWB | ADDI writeback
// JUMP   | PC <- jump target
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] RST    = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] DECODE = 4'd2;
  localparam logic [3:0] MEMADR = 4'd3;
  localparam logic [3:0] MEMRD  = 4'd4;
  localparam logic [3:0] MEMWB  = 4'd5;
  localparam logic [3:0] MEMWR  = 4'd6;
  localparam logic [3:0] EXEC   = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
  localparam logic [3:0] JUMP   = 4'd12;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b00001;
  localparam logic [4:0] OP_SW   = 5'b00010;
  localparam logic [4:0] OP_BEQ  = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_J    = 5'b00101;

  logic [3:0]       state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             bad_op;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    bad_op  = 1'b0;
    case (state_q)
      RST:    state_d = FETCH;
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_R:         state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:  begin state_d = FETCH; retire = 1'b1; end
      MEMWR:  if (bus.mem_ready) begin state_d = FETCH; retire = 1'b1; end
      EXEC:   state_d = ALUWB;
      ALUWB:  begin state_d = FETCH; retire = 1'b1; end
      BRANCH: begin state_d = FETCH; retire = 1'b1; end
      ADDIEX: state_d = ADDIWB;
      ADDIWB: begin state_d = FETCH; retire = 1'b1; end
      JUMP:   begin state_d = FETCH; retire = 1'b1; end
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | bad_op;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end

  // Outputs decode from state only, except the FETCH strobes that wait on memory.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.regwrite = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.aluop    = 2'b00;
    case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
      end
      DECODE: bus.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.branch  = 1'b1;
      end
      ADDIWB: bus.regwrite = 1'b1;
      JUMP: begin
        bus.pcwrite = 1'b1;
        bus.pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.pcen    = bus.pcwrite | (bus.branch & bus.zero);
  assign bus.illegal = illegal_q;
  assign bus.instret = instret_q;
endmodule
